muldiv_ctrl: RTL and testbench

//  Multi-cycle multiply/divide sequencer that owns all HI/LO writes from arithmetic ops.

---
 rtl/muldiv_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//   Multi-cycle multiply/divide sequencer for the EX stage. It accepts one
//   op from decode, stalls the front of the pipeline while it works, and then
//   pulses hilo_wen_o for one cycle with the 2*XLEN-bit {HI,LO} result. It is
//   the only writer of HI/LO for arithmetic ops. Accumulate ops (MADD/MSUB)
//   latch the forwarded {HI,LO} value when the op is accepted. A flush aborts
//   any op in flight without writing HI/LO.
//
//   Ports
//     clk_i          clock; all state updates on the rising edge
//     rst_i          synchronous reset, active high
//     start_i        EX holds a muldiv op (held high for the whole stall)
//     op_i           000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                    100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
//     opa_i          rs operand (dividend / multiplicand)
//     opb_i          rt operand (divisor / multiplier)
//     flush_i        abort any op; no HI/LO write this cycle
//     hilo_rdata_i   current {HI,LO}, already forwarded
//     stall_req_o    hold IF..EX this cycle
//     busy_o         sequencer is not idle
//     hilo_wen_o     one-cycle HI/LO write strobe
//     hilo_wdata_o   {HI,LO} result; holds the last written value otherwise
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [2:0]          op_i,
  input  logic [XLEN-1:0]     opa_i,
  input  logic [XLEN-1:0]     opb_i,
  input  logic                flush_i,
  input  logic [2*XLEN-1:0]   hilo_rdata_i,
  output logic                stall_req_o,
  output logic                busy_o,
  output logic                hilo_wen_o,
  output logic [2*XLEN-1:0]   hilo_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ACC  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // The counter must reach XLEN: XLEN quotient-bit cycles (0..XLEN-1) are
  // followed by one cycle that converts the magnitudes to signed results.
  localparam int              CW        = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_FINAL = CW'(XLEN);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [XLEN-1:0]      a_q, a_d;
  logic [XLEN-1:0]      b_q, b_d;
  logic [2*XLEN-1:0]    acc_q, acc_d;
  logic [2*XLEN-1:0]    result_q, result_d;
  logic [2*XLEN-1:0]    last_q, last_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;

  // Decode of the incoming op.
  logic                 in_is_div;
  logic                 in_signed;
  logic [XLEN-1:0]      abs_a;
  logic [XLEN-1:0]      abs_b;

  assign in_is_div = (op_i[2:1] == 2'b01);
  assign in_signed = ~op_i[0];
  assign abs_a     = (in_signed && opa_i[XLEN-1]) ? -opa_i : opa_i;
  assign abs_b     = (in_signed && opb_i[XLEN-1]) ? -opb_i : opb_i;

  // Multiplier: sign- or zero-extend to 2*XLEN and keep the low 2*XLEN bits,
  // which is the exact signed/unsigned product modulo 2^(2*XLEN).
  logic [2*XLEN-1:0]    ext_a;
  logic [2*XLEN-1:0]    ext_b;
  logic [2*XLEN-1:0]    product;

  assign ext_a   = op_q[0] ? {{XLEN{1'b0}}, a_q} : {{XLEN{a_q[XLEN-1]}}, a_q};
  assign ext_b   = op_q[0] ? {{XLEN{1'b0}}, b_q} : {{XLEN{b_q[XLEN-1]}}, b_q};
  assign product = ext_a * ext_b;

  // Restoring divider step. quo_q starts as the dividend magnitude; its MSB
  // is shifted into the partial remainder while quotient bits enter at the
  // LSB. One extra bit on the trial value holds the borrow.
  logic [XLEN:0]        shifted;
  logic [XLEN:0]        trial;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // NOTE: every signal written here gets its default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    last_d   = last_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          a_d   = opa_i;
          b_d   = opb_i;
          acc_d = hilo_rdata_i;
          cnt_d = '0;
          if (in_is_div) begin
            if (opb_i == '0) begin
              // Divide by zero: HI keeps the dividend, LO is all ones.
              result_d = {opa_i, {XLEN{1'b1}}};
              state_d  = S_DONE;
            end else begin
              rem_d   = '0;
              quo_d   = abs_a;
              dvs_d   = abs_b;
              qneg_d  = in_signed & (opa_i[XLEN-1] ^ opb_i[XLEN-1]);
              rneg_d  = in_signed & opa_i[XLEN-1];
              state_d = S_DIV;
            end
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        result_d = product;
        state_d  = op_q[2] ? S_ACC : S_DONE;
      end

      S_ACC: begin
        // op bit 1 selects subtract for MSUB/MSUBU.
        result_d = op_q[1] ? (acc_q - result_q) : (acc_q + result_q);
        state_d  = S_DONE;
      end

      S_DIV: begin
        if (cnt_q == CNT_FINAL) begin
          // Quotient truncates toward zero; remainder follows the dividend.
          result_d = {rneg_q ? -rem_q : rem_q, qneg_q ? -quo_q : quo_q};
          state_d  = S_DONE;
        end else begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // start_i may still be high here; it is only sampled in IDLE.
        last_d  = result_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything: nothing is launched or committed.
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      last_d  = last_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the datapath registers are reset too, because hilo_wdata_o
      // must read 0 after reset and a reset mid-op must leave nothing behind.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      last_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  // Outputs. The stall request is combinational so decode is held in the
  // same cycle the op is first presented.
  always_comb begin
    stall_req_o  = ((state_q == S_IDLE) && start_i && !flush_i) ||
                   (state_q == S_MUL) || (state_q == S_ACC) ||
                   (state_q == S_DIV);
    busy_o       = (state_q != S_IDLE);
    hilo_wen_o   = (state_q == S_DONE) && !flush_i;
    hilo_wdata_o = hilo_wen_o ? result_q : last_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl (XLEN=32). Inputs change on the falling
//   edge; outputs are sampled 1ns later, well away from the rising edge.
//   Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic [63:0] hilo_rdata;
  logic        stall_req;
  logic        busy;
  logic        hilo_wen;
  logic [63:0] hilo_wdata;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .op_i         (op),
    .opa_i        (opa),
    .opb_i        (opb),
    .flush_i      (flush),
    .hilo_rdata_i (hilo_rdata),
    .stall_req_o  (stall_req),
    .busy_o       (busy),
    .hilo_wen_o   (hilo_wen),
    .hilo_wdata_o (hilo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op, wait (bounded) for the write strobe, check latency,
  // stall length and result, then confirm the sequencer idles with start
  // still high through DONE.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] acc, input int lat,
                       input logic [63:0] exp);
    int k;
    int stalls;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; hilo_rdata = acc;
    #1;
    check({tag, "/stall_first"}, stall_req, 1);
    check({tag, "/no_wen_first"}, hilo_wen, 0);
    stalls = 1;
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (hilo_wen) break;
      if (stall_req) stalls++;
    end
    check({tag, "/latency"}, k, lat);
    check({tag, "/stall_cycles"}, stalls, lat);
    check({tag, "/wdata"}, hilo_wdata, exp);
    check({tag, "/done_stall"}, stall_req, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "/idle_busy"}, busy, 0);
    check({tag, "/idle_wen"}, hilo_wen, 0);
    check({tag, "/hold_wdata"}, hilo_wdata, exp);
  endtask

  initial begin
    int k;
    int wens;

    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
    flush = 1'b0; hilo_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset/busy", busy, 0);
    check("reset/stall", stall_req, 0);
    check("reset/wen", hilo_wen, 0);
    check("reset/wdata", hilo_wdata, 64'h0);
    rst = 1'b0;

    // Multiplies.
    do_op("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,        64'h0, 2, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 2, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_ext",   OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 64'h0, 2, 64'hC000_0000_8000_0000);

    // Accumulates.
    do_op("madd",  OP_MADD,  32'hFFFF_FFFE, 32'd4, 64'h0000_0000_0000_0010, 3, 64'h0000_0000_0000_0008);
    do_op("msub",  OP_MSUB,  32'd3,         32'd5, 64'h0000_0000_0000_0010, 3, 64'h0000_0000_0000_0001);
    do_op("msubu", OP_MSUBU, 32'd1,         32'd1, 64'h0,                   3, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("maddu", OP_MADDU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_0000_0000, 3, 64'h0000_0002_FFFF_FFFE);

    // Divides.
    do_op("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         64'h0, 34, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_big",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 34, 64'h8000_0000_0000_0000);
    do_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 34, 64'h0000_0000_8000_0000);
    do_op("divu_100",  OP_DIVU, 32'd100,       32'd7,         64'h0, 34, 64'h0000_0002_0000_000E);
    do_op("div_negb",  OP_DIV,  32'd7,         32'hFFFF_FFFE, 64'h0, 34, 64'h0000_0001_FFFF_FFFD);
    do_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0,         64'h0, 1,  64'h0000_1234_FFFF_FFFF);
    do_op("div_zero",  OP_DIV,  32'hFFFF_FFF9, 32'd0,         64'h0, 1,  64'hFFFF_FFF9_FFFF_FFFF);

    // Flush during a divide at iteration 10.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; opa = 32'd1000; opb = 32'd3;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_div/no_wen", hilo_wen, 0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_div/busy", busy, 0);
    check("flush_div/stall", stall_req, 0);
    wens = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (hilo_wen) wens++;
    end
    check("flush_div/no_strobe", wens, 0);
    check("flush_div/wdata_kept", hilo_wdata, 64'hFFFF_FFF9_FFFF_FFFF);
    do_op("mult_after_flush", OP_MULT, 32'd6, 32'd7, 64'h0, 2, 64'h0000_0000_0000_002A);

    // flush together with start in IDLE launches nothing.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; opa = 32'd5; opb = 32'd5;
    #1;
    check("flush_start/stall", stall_req, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start/busy", busy, 0);
    @(negedge clk);
    #1;
    check("flush_start/no_wen", hilo_wen, 0);

    // Flush in DONE suppresses the write strobe.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; opa = 32'd9; opb = 32'd9;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("flush_done/pre_wen", hilo_wen, 1);
    flush = 1'b1;
    #1;
    check("flush_done/wen", hilo_wen, 0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_done/busy", busy, 0);
    check("flush_done/no_wen", hilo_wen, 0);

    // Reset mid-op clears the result registers.
    @(negedge clk);
    start = 1'b1; op = OP_MADD; opa = 32'd3; opb = 32'd3; hilo_rdata = 64'd1;
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid/busy", busy, 0);
    check("rst_mid/wdata", hilo_wdata, 64'h0);
    wens = 0;
    for (k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (hilo_wen) wens++;
    end
    check("rst_mid/no_strobe", wens, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
